uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver; consumes oversampling ticks from the baud-rate generator. Data length (5..NB_DATA), parity (none/even/odd) and stop bits (1/2) are configurable at runtime. Adds an input synchroniser, false-start rejection, and parity/framing error reporting. Sits between the pad-side rx line and the rx FIFO/interface block.

Parameters:
NB_DATA, 8, maximum data bits per frame (legal 5..9); sizes o_data.
OVS, 16, ticks per bit period (even, >=4); start bit is checked after OVS/2 ticks.

Ports:
i_clk  in  1  system clock; sole clock.
i_reset  in  1  synchronous, active-high reset.
i_rx  in  1  asynchronous serial line, idle high.
i_tick  in  1  oversampling strobe from baud generator, 1-cycle pulse.
i_nbits  in  4  data bits per frame; <5 treated as 5, >NB_DATA treated as NB_DATA.
i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
i_stop2  in  1  1 = two stop bits checked.
o_data  out  NB_DATA  last received word, right-aligned, bits >= nbits are zero.
o_rx_done_tick  out  1  1-cycle pulse: frame complete, o_data/error flags updated.
o_parity_err  out  1  parity mismatch in last frame (0 when parity none).
o_frame_err  out  1  a stop bit sampled low in last frame.
o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, i_clk edge with i_reset=1): state IDLE, counters 0, synchroniser flops 1; o_data=0, o_rx_done_tick=0, o_parity_err=0, o_frame_err=0, o_busy=0. Reset mid-frame aborts it, no done pulse.
- i_rx passes a 2-flop synchroniser (rx_s); all decisions use rx_s (2-cycle input latency).
- Counters: s (ticks) $clog2(OVS) bits; n (bits) $clog2(NB_DATA+1) bits; shift register NB_DATA bits, LSB-first.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: i_tick ignored. rx_s==0 -> START, s=0; latch i_nbits (clamped), i_parity_mode, i_stop2 into frame config. Config changes mid-frame have no effect.
- START: per tick, at s==OVS/2-1: rx_s==0 -> DATA, s=0, n=0, shift reg=0; rx_s==1 -> IDLE (false start, no pulse, flags unchanged). Else s++.
- DATA: per tick, at s==OVS-1: sample rx_s into bit n, s=0; n==nbits-1 -> PARITY if parity enabled else STOP; else n++. Else s++.
- PARITY: per tick, at s==OVS-1: compute perr = (XOR of data bits ^ rx_s) != (odd?1:0); s=0 -> STOP.
- STOP: per tick, at s==OVS-1: rx_s==0 sets ferr; s=0. If stop2 and first stop bit: stay, count again. On last stop bit: o_data<=assembled word, o_parity_err<=perr, o_frame_err<=ferr (accumulated over both stops), o_rx_done_tick=1 for that one cycle; next state IDLE if rx_s==1 else WAIT_HIGH.
- WAIT_HIGH (break/line-low recovery): stay until rx_s==1, then IDLE; no new frame is started from a low line.
- o_rx_done_tick is registered; outputs hold between frames.
- i_tick in the same cycle as a state entry counts toward the new state.
- Unreachable state encodings -> IDLE with counters cleared.

Decomposition:
- Package uart_pkg: state encodings, parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), min data bits (5). Shared with the matching transmitter.
- Sub-module sync_2ff (parametrised reset value, here 1); reused by other async inputs.

Test Plan:
- OVS=16, tick every clock, 8N1, send 0xA5 -> single done pulse after ~9.5 bit periods, o_data=0xA5, both errors 0.
- 7E1, send 0x41 with correct parity bit 0 -> o_data=0x41, o_parity_err=0; repeat with parity bit 1 -> o_parity_err=1, data still 0x41.
- 5O2, send 0x1F, second stop bit driven low -> o_data=0x1F, o_frame_err=1, state WAIT_HIGH until line released, then IDLE.
- Low glitch of 4 ticks on idle line -> no done pulse, o_busy returns 0, outputs unchanged.
- Line held low 20 bit periods (break) -> one done with o_data=0, o_frame_err=1; no second frame until the line goes high.
- Assert i_reset during DATA bit 3 -> next cycle all outputs 0, o_busy=0; following 0x3C frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, parity modes and frame limits.
// Used by the configurable receiver and the matching transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned MIN_DATA_BITS = 5;

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is a parameter
// so that idle-high lines come out of reset in their idle state.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5..NB_DATA data bits, none/even/odd parity,
// 1 or 2 stop bits) driven by an oversampling tick, with false-start rejection.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned OVS     = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx,
    input  logic               i_tick,
    input  logic [3:0]         i_nbits,
    input  logic [1:0]         i_parity_mode,
    input  logic               i_stop2,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done_tick,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int unsigned S_W = $clog2(OVS);
    localparam int unsigned N_W = $clog2(NB_DATA + 1);

    logic w_rx_s;

    rx_state_e          r_state,       w_state_next;
    logic [S_W-1:0]     r_s,           w_s_next;
    logic [N_W-1:0]     r_n,           w_n_next;
    logic [NB_DATA-1:0] r_shift,       w_shift_next;
    logic [N_W-1:0]     r_nbits,       w_nbits_next;
    logic               r_par_en,      w_par_en_next;
    logic               r_par_odd,     w_par_odd_next;
    logic               r_stop2,       w_stop2_next;
    logic               r_stop_second, w_stop_second_next;
    logic               r_perr,        w_perr_next;
    logic               r_ferr,        w_ferr_next;
    logic [NB_DATA-1:0] r_data,        w_data_next;
    logic               r_done,        w_done_next;
    logic               r_perr_out,    w_perr_out_next;
    logic               r_ferr_out,    w_ferr_out_next;
    logic               r_busy,        w_busy_next;
    logic [N_W-1:0]     w_nbits_clamped;
    logic               w_ferr_acc;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (w_rx_s)
    );

    // Clamp the requested word length into the supported range.
    always_comb begin
        if (i_nbits < 4'(MIN_DATA_BITS)) begin
            w_nbits_clamped = N_W'(MIN_DATA_BITS);
        end else if (i_nbits > 4'(NB_DATA)) begin
            w_nbits_clamped = N_W'(NB_DATA);
        end else begin
            w_nbits_clamped = N_W'(i_nbits);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_s           <= '0;
            r_n           <= '0;
            r_shift       <= '0;
            r_nbits       <= N_W'(NB_DATA);
            r_par_en      <= 1'b0;
            r_par_odd     <= 1'b0;
            r_stop2       <= 1'b0;
            r_stop_second <= 1'b0;
            r_perr        <= 1'b0;
            r_ferr        <= 1'b0;
            r_data        <= '0;
            r_done        <= 1'b0;
            r_perr_out    <= 1'b0;
            r_ferr_out    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_s           <= w_s_next;
            r_n           <= w_n_next;
            r_shift       <= w_shift_next;
            r_nbits       <= w_nbits_next;
            r_par_en      <= w_par_en_next;
            r_par_odd     <= w_par_odd_next;
            r_stop2       <= w_stop2_next;
            r_stop_second <= w_stop_second_next;
            r_perr        <= w_perr_next;
            r_ferr        <= w_ferr_next;
            r_data        <= w_data_next;
            r_done        <= w_done_next;
            r_perr_out    <= w_perr_out_next;
            r_ferr_out    <= w_ferr_out_next;
            r_busy        <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_s_next           = r_s;
        w_n_next           = r_n;
        w_shift_next       = r_shift;
        w_nbits_next       = r_nbits;
        w_par_en_next      = r_par_en;
        w_par_odd_next     = r_par_odd;
        w_stop2_next       = r_stop2;
        w_stop_second_next = r_stop_second;
        w_perr_next        = r_perr;
        w_ferr_next        = r_ferr;
        w_data_next        = r_data;
        w_done_next        = 1'b0;
        w_perr_out_next    = r_perr_out;
        w_ferr_out_next    = r_ferr_out;
        w_ferr_acc         = r_ferr | ~w_rx_s;

        case (r_state)
            // Frame configuration is frozen at the falling edge of the start bit.
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next   = ST_START;
                    w_s_next       = '0;
                    w_nbits_next   = w_nbits_clamped;
                    w_par_en_next  = par_enabled(i_parity_mode);
                    w_par_odd_next = (i_parity_mode == PAR_ODD);
                    w_stop2_next   = i_stop2;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (r_s == S_W'(OVS / 2 - 1)) begin
                        w_s_next = '0;
                        if (!w_rx_s) begin
                            w_state_next       = ST_DATA;
                            w_n_next           = '0;
                            w_shift_next       = '0;
                            w_perr_next        = 1'b0;
                            w_ferr_next        = 1'b0;
                            w_stop_second_next = 1'b0;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (r_s == S_W'(OVS - 1)) begin
                        w_s_next = '0;
                        for (int i = 0; i < int'(NB_DATA); i++) begin
                            if (r_n == N_W'(i)) begin
                                w_shift_next[i] = w_rx_s;
                            end
                        end
                        if (r_n == r_nbits - N_W'(1)) begin
                            w_state_next = r_par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            w_n_next = r_n + N_W'(1);
                        end
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (i_tick) begin
                    if (r_s == S_W'(OVS - 1)) begin
                        w_s_next     = '0;
                        w_perr_next  = ((^r_shift) ^ w_rx_s) != r_par_odd;
                        w_state_next = ST_STOP;
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
            // Framing error accumulates across both stop bits when two are configured.
            ST_STOP: begin
                if (i_tick) begin
                    if (r_s == S_W'(OVS - 1)) begin
                        w_s_next    = '0;
                        w_ferr_next = w_ferr_acc;
                        if (r_stop2 && !r_stop_second) begin
                            w_stop_second_next = 1'b1;
                        end else begin
                            w_data_next     = r_shift;
                            w_perr_out_next = r_perr;
                            w_ferr_out_next = w_ferr_acc;
                            w_done_next     = 1'b1;
                            w_state_next    = w_rx_s ? ST_IDLE : ST_WAIT_HIGH;
                        end
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (w_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_s_next     = '0;
                w_n_next     = '0;
            end
        endcase

        w_busy_next = (w_state_next != ST_IDLE);
    end

    assign o_data         = r_data;
    assign o_rx_done_tick = r_done;
    assign o_parity_err   = r_perr_out;
    assign o_frame_err    = r_ferr_out;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed self-checking bench for uart_rx_cfg (OVS=16, tick every clock).
module tb_uart_rx_cfg;

    localparam int unsigned NB_DATA = 8;
    localparam int unsigned OVS     = 16;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic               i_rx;
    logic               i_tick;
    logic [3:0]         i_nbits;
    logic [1:0]         i_parity_mode;
    logic               i_stop2;
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done_tick;
    logic               o_parity_err;
    logic               o_frame_err;
    logic               o_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    uart_rx_cfg #(.NB_DATA(NB_DATA), .OVS(OVS)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_rx           (i_rx),
        .i_tick         (i_tick),
        .i_nbits        (i_nbits),
        .i_parity_mode  (i_parity_mode),
        .i_stop2        (i_stop2),
        .o_data         (o_data),
        .o_rx_done_tick (o_rx_done_tick),
        .o_parity_err   (o_parity_err),
        .o_frame_err    (o_frame_err),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_rx_done_tick) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic drive_bit(input logic b);
        i_rx = b;
        repeat (OVS) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [8:0] data, input int nbits, input logic has_par,
                              input logic par_bit, input logic stop_a, input logic stop_b,
                              input logic two_stop);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(data[i]);
        if (has_par) drive_bit(par_bit);
        drive_bit(stop_a);
        if (two_stop) drive_bit(stop_b);
    endtask

    task automatic set_cfg(input logic [3:0] nb, input logic [1:0] pm, input logic s2);
        i_nbits       = nb;
        i_parity_mode = pm;
        i_stop2       = s2;
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        i_rx    = 1'b1;
        i_tick  = 1'b1;
        set_cfg(4'd8, 2'b00, 1'b0);
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (o_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h exp 00", o_data); end
        n_cmp++; if (o_rx_done_tick !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", o_rx_done_tick); end
        n_cmp++; if (o_parity_err !== 1'b0) begin n_err++; $display("FAIL reset_perr got %b exp 0", o_parity_err); end
        n_cmp++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got %b exp 0", o_frame_err); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        repeat (20) @(negedge i_clk);
    endtask

    task automatic test_8n1;
        int d0, t0, lat;
        set_cfg(4'd8, 2'b00, 1'b0);
        d0 = done_cnt;
        t0 = cyc;
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (8) @(negedge i_clk);
        lat = done_cyc - t0;
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL 8n1_done_count got %0d exp 1", done_cnt - d0); end
        n_cmp++; if (lat < 150 || lat > 160) begin n_err++; $display("FAIL 8n1_latency got %0d exp 150..160", lat); end
        n_cmp++; if (o_data !== 8'hA5) begin n_err++; $display("FAIL 8n1_data got %h exp a5", o_data); end
        n_cmp++; if (o_parity_err !== 1'b0) begin n_err++; $display("FAIL 8n1_perr got %b exp 0", o_parity_err); end
        n_cmp++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL 8n1_ferr got %b exp 0", o_frame_err); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL 8n1_busy_after got %b exp 0", o_busy); end
    endtask

    task automatic test_7e1;
        int d0;
        set_cfg(4'd7, 2'b01, 1'b0);
        for (int k = 0; k < 2; k++) begin
            d0 = done_cnt;
            send_frame(9'h041, 7, 1'b1, 1'(k), 1'b1, 1'b1, 1'b0);
            repeat (8) @(negedge i_clk);
            n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL 7e1_done_count[%0d] got %0d exp 1", k, done_cnt - d0); end
            n_cmp++; if (o_data !== 8'h41) begin n_err++; $display("FAIL 7e1_data[%0d] got %h exp 41", k, o_data); end
            n_cmp++; if (o_parity_err !== 1'(k)) begin n_err++; $display("FAIL 7e1_perr[%0d] got %b exp %0d", k, o_parity_err, k); end
            n_cmp++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL 7e1_ferr[%0d] got %b exp 0", k, o_frame_err); end
        end
    endtask

    task automatic test_glitch;
        int d0;
        set_cfg(4'd8, 2'b00, 1'b0);
        d0 = done_cnt;
        i_rx = 1'b0;
        repeat (4) @(negedge i_clk);
        i_rx = 1'b1;
        repeat (40) @(negedge i_clk);
        n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL glitch_done_count got %0d exp 0", done_cnt - d0); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy got %b exp 0", o_busy); end
        n_cmp++; if (o_data !== 8'h41) begin n_err++; $display("FAIL glitch_data got %h exp 41", o_data); end
        n_cmp++; if (o_parity_err !== 1'b1) begin n_err++; $display("FAIL glitch_perr got %b exp 1", o_parity_err); end
    endtask

    task automatic test_5o2;
        int d0;
        set_cfg(4'd5, 2'b10, 1'b1);
        d0 = done_cnt;
        // 0x1F has five ones, so the odd-parity bit is 0.
        send_frame(9'h01F, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (32) @(negedge i_clk);
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL 5o2_done_count got %0d exp 1", done_cnt - d0); end
        n_cmp++; if (o_data !== 8'h1F) begin n_err++; $display("FAIL 5o2_data got %h exp 1f", o_data); end
        n_cmp++; if (o_frame_err !== 1'b1) begin n_err++; $display("FAIL 5o2_ferr got %b exp 1", o_frame_err); end
        n_cmp++; if (o_parity_err !== 1'b0) begin n_err++; $display("FAIL 5o2_perr got %b exp 0", o_parity_err); end
        n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL 5o2_wait_high_busy got %b exp 1", o_busy); end
        i_rx = 1'b1;
        repeat (8) @(negedge i_clk);
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL 5o2_released_busy got %b exp 0", o_busy); end
        repeat (16) @(negedge i_clk);
    endtask

    task automatic test_break;
        int d0;
        set_cfg(4'd8, 2'b00, 1'b0);
        d0 = done_cnt;
        i_rx = 1'b0;
        repeat (20 * OVS) @(negedge i_clk);
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL break_done_count got %0d exp 1", done_cnt - d0); end
        n_cmp++; if (o_data !== 8'h00) begin n_err++; $display("FAIL break_data got %h exp 00", o_data); end
        n_cmp++; if (o_frame_err !== 1'b1) begin n_err++; $display("FAIL break_ferr got %b exp 1", o_frame_err); end
        n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL break_busy got %b exp 1", o_busy); end
        i_rx = 1'b1;
        repeat (40) @(negedge i_clk);
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL break_after_done_count got %0d exp 1", done_cnt - d0); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL break_after_busy got %b exp 0", o_busy); end
    endtask

    task automatic test_reset_midframe;
        int d0;
        set_cfg(4'd8, 2'b00, 1'b0);
        d0 = done_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        i_rx = 1'b0;
        repeat (OVS / 2) @(negedge i_clk);
        n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL midframe_busy got %b exp 1", o_busy); end
        i_reset = 1'b1;
        i_rx    = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        n_cmp++; if (o_data !== 8'h00) begin n_err++; $display("FAIL midrst_data got %h exp 00", o_data); end
        n_cmp++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL midrst_ferr got %b exp 0", o_frame_err); end
        n_cmp++; if (o_parity_err !== 1'b0) begin n_err++; $display("FAIL midrst_perr got %b exp 0", o_parity_err); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", o_busy); end
        repeat (2 * OVS) @(negedge i_clk);
        n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL midrst_no_done got %0d exp 0", done_cnt - d0); end
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (8) @(negedge i_clk);
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL post_rst_done_count got %0d exp 1", done_cnt - d0); end
        n_cmp++; if (o_data !== 8'h3C) begin n_err++; $display("FAIL post_rst_data got %h exp 3c", o_data); end
        n_cmp++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL post_rst_ferr got %b exp 0", o_frame_err); end
        n_cmp++; if (o_parity_err !== 1'b0) begin n_err++; $display("FAIL post_rst_perr got %b exp 0", o_parity_err); end
    endtask

    initial begin
        i_reset = 1'b1;
        i_rx    = 1'b1;
        i_tick  = 1'b1;
        set_cfg(4'd8, 2'b00, 1'b0);
        @(negedge i_clk);
        test_reset();
        test_8n1();
        test_7e1();
        test_glitch();
        test_5o2();
        test_break();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
